// File: rtl/bf16_dotprod_pipe.sv
// bf16_dotprod_pipe: pipelined bfloat16 dot product (VEC_LEN lanes per beat) with multi-beat packet accumulation.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_last with horz/vert (lane i at [i*16 +: 16]);
//        out_valid/out_ready with out_data (bfloat16 packet result).
// Optional: define BF16_DOTPROD_NAN_FLAG_EN to add out_nan, a sticky per-packet NaN indicator.
// Arithmetic cells: round-to-nearest-even, denormals read as zero, underflow flushes to signed zero,
// overflow gives Inf, any NaN result is the canonical 0x7FC0.
module bf16_dotprod_pipe #(
  parameter int VEC_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [VEC_LEN*16-1:0] horz,
  input  logic [VEC_LEN*16-1:0] vert,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data
`ifdef BF16_DOTPROD_NAN_FLAG_EN
  ,
  output logic                 out_nan
`endif
);
  localparam int LOG2_LEN = $clog2(VEC_LEN);
  localparam int NODES = 2 * VEC_LEN - 1;

  if (VEC_LEN < 2 || (VEC_LEN & (VEC_LEN - 1)) != 0) begin : g_bad_len
    $fatal(1, "bf16_dotprod_pipe: VEC_LEN must be a power of 2 and at least 2");
  end

  function automatic logic is_nan(logic [15:0] x);
    return (&x[14:7]) && (|x[6:0]);
  endfunction

  // m carries the hidden bit; g/st are guard and sticky below it
  function automatic logic [15:0] pack(logic s, int e, logic [7:0] m, logic g, logic st);
    logic [8:0] r;
    r = {1'b0, m} + 9'(g & (st | m[0]));
    if (r[8]) begin
      e = e + 1;
      r = r >> 1;
    end
    if (e >= 255) return {s, 8'hFF, 7'h0};
    if (e <= 0) return {s, 15'h0};
    return {s, e[7:0], r[6:0]};
  endfunction

  function automatic logic [15:0] bf16_mul(logic [15:0] a, logic [15:0] b);
    logic s;
    logic [15:0] p;
    int e;
    s = a[15] ^ b[15];
    if (is_nan(a) || is_nan(b) || (&a[14:7] && b[14:7] == 8'h0) || (&b[14:7] && a[14:7] == 8'h0))
      return 16'h7FC0;
    if (&a[14:7] || &b[14:7]) return {s, 8'hFF, 7'h0};
    if (a[14:7] == 8'h0 || b[14:7] == 8'h0) return {s, 15'h0};
    p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) return pack(s, e + 1, p[15:8], p[7], |p[6:0]);
    return pack(s, e, p[14:7], p[6], |p[5:0]);
  endfunction

  function automatic logic [15:0] bf16_add(logic [15:0] a, logic [15:0] b);
    logic [15:0] x, y;
    logic [18:0] mx, my, r, n;
    int d, p;
    if (is_nan(a) || is_nan(b) || (&a[14:7] && &b[14:7] && a[15] != b[15])) return 16'h7FC0;
    if (&a[14:7]) return a;
    if (&b[14:7]) return b;
    if (a[14:7] == 8'h0 && b[14:7] == 8'h0) return {a[15] & b[15], 15'h0};
    if (a[14:7] == 8'h0) return b;
    if (b[14:7] == 8'h0) return a;
    {x, y} = (a[14:0] >= b[14:0]) ? {a, b} : {b, a};
    d = int'(x[14:7]) - int'(y[14:7]);
    // a smaller operand 10+ binades down is below half an ulp and cannot move the result
    if (d >= 10) return x;
    mx = {2'b01, x[6:0], 10'h0};
    my = {2'b01, y[6:0], 10'h0} >> d;
    r = (x[15] == y[15]) ? mx + my : mx - my;
    if (r == 19'h0) return 16'h0;
    p = 0;
    for (int i = 0; i < 19; i++) if (r[i]) p = i;
    n = r << (18 - p);
    return pack(x[15], int'(x[14:7]) + p - 17, n[18:11], n[10], |n[9:0]);
  endfunction

  logic                  w_stall;
  logic                  r_s0_v, r_s0_last;
  logic [VEC_LEN*16-1:0] r_s0_h, r_s0_vt;
  // node storage: products at [0, VEC_LEN), then each tree level packed after the previous one
  logic [15:0]           r_node [NODES];
  logic [15:0]           w_node [NODES];
  logic [LOG2_LEN:0]     r_v, r_last;
  logic [15:0]           r_acc, w_root, w_acc_new;
  logic                  r_first, w_done;

  assign w_stall = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_root = r_node[NODES-1];
  assign w_acc_new = r_first ? w_root : bf16_add(r_acc, w_root);
  assign w_done = r_v[LOG2_LEN] && r_last[LOG2_LEN];

  for (genvar i = 0; i < VEC_LEN; i++) begin : g_mul
    assign w_node[i] = bf16_mul(r_s0_h[i*16 +: 16], r_s0_vt[i*16 +: 16]);
  end

  for (genvar k = 1; k <= LOG2_LEN; k++) begin : g_lvl
    for (genvar j = 0; j < (VEC_LEN >> k); j++) begin : g_node
      localparam int lo = 2 * VEC_LEN - ((2 * VEC_LEN) >> k);
      localparam int ch = 2 * VEC_LEN - ((4 * VEC_LEN) >> k) + 2 * j;
      assign w_node[lo + j] = bf16_add(r_node[ch], r_node[ch + 1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_s0_h <= horz;
      r_s0_vt <= vert;
      r_s0_last <= in_last;
      r_last <= {r_last[LOG2_LEN-1:0], r_s0_last};
      for (int i = 0; i < NODES; i++) r_node[i] <= w_node[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_v <= 1'b0;
      r_v <= '0;
      r_acc <= 16'h0;
      r_first <= 1'b1;
      out_valid <= 1'b0;
      out_data <= 16'h0;
    end else if (!w_stall) begin
      r_s0_v <= in_valid;
      r_v <= {r_v[LOG2_LEN-1:0], r_s0_v};
      if (r_v[LOG2_LEN]) begin
        r_acc <= r_last[LOG2_LEN] ? 16'h0 : w_acc_new;
        r_first <= r_last[LOG2_LEN];
      end
      out_valid <= w_done;
      if (w_done) out_data <= w_acc_new;
    end
  end

`ifdef BF16_DOTPROD_NAN_FLAG_EN
  // NaN propagates through every adder, so the root sum and the new accumulator cover all intermediates
  logic r_nan, w_nan_new;
  assign w_nan_new = r_nan | is_nan(w_root) | is_nan(w_acc_new);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nan <= 1'b0;
      out_nan <= 1'b0;
    end else if (!w_stall && r_v[LOG2_LEN]) begin
      r_nan <= r_last[LOG2_LEN] ? 1'b0 : w_nan_new;
      if (r_last[LOG2_LEN]) out_nan <= w_nan_new;
    end
  end
`endif
endmodule

// File: doc/bf16_dotprod_pipe.md
Name: bf16_dotprod_pipe

Overview:
- Parametrised, fully pipelined bfloat16 dot-product engine with a valid/ready handshake and multi-beat accumulation.
- Each beat multiplies VEC_LEN lane pairs and reduces the products through a registered log2 adder tree.
- The per-beat sums of a packet (beats up to and including the one with in_last) are accumulated into one bfloat16 result.
- Built from the team's existing bfloat16_mult and bfloat16_adder cells. Sits between operand buffers and the result writeback path.

Parameters:
- VEC_LEN, 8, lanes per beat. Must be a power of 2, ≥2. Checked at elaboration; a non-power-of-2 value is a fatal error.
- LOG2_LEN, derived = log2(VEC_LEN), adder tree depth. Not user-overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat present on horz/vert/in_last
- in_ready  out  1  block accepts beat this cycle
- in_last  in  1  final beat of current packet
- horz  in  VEC_LEN*16  lane i at bits [i*16 +: 16], bfloat16
- vert  in  VEC_LEN*16  same layout as horz
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  16  bfloat16 dot product of packet

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0:
  - out_valid=0, out_data=0x0000.
  - All stage valid bits = 0, accumulator = 0x0000, first-beat flag = 1.
  - in_ready follows its combinational rule (1 after reset).
- Reset mid-packet: discards the partial packet and in-flight beats. The next accepted beat starts a new packet.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational, no dependency on in_valid).
- Stall freezes every pipeline register, valid bit and the accumulator. out_data is held stable while stalled.
- Stages (one register each, valid bit travels with data):
  - S0: captures horz, vert, in_last.
  - S1: VEC_LEN products registered.
  - S2..S(1+LOG2_LEN): tree levels. Level k pairs adjacent entries: lane 2j + lane 2j+1. Addition order is fixed.
  - ACC: accumulate and output stage.
- Bubbles (in_valid=0) propagate as invalid and never modify the accumulator.
- ACC stage, on a valid tree sum s:
  - Not last, first beat of packet: acc <= s (load, no add; preserves -0), first <= 0.
  - Not last, otherwise: acc <= acc + s via bfloat16_adder.
  - Last: out_data <= (first ? s : acc + s), out_valid <= 1, acc <= 0x0000, first <= 1.
- Accumulation order is strictly beat order: ((s0+s1)+s2)+...
- out_valid clears on consume. If a new last-beat result and a consume occur in the same cycle, out_valid stays 1 and out_data takes the new value.
- Latency: the last beat accepted at cycle t gives out_valid=1 at t+LOG2_LEN+3 absent stalls (6 for VEC_LEN=8).
- Throughput: one beat per cycle. Single-beat packets back-to-back yield one result per cycle when out_ready=1.
- Arithmetic, rounding, denormal and NaN/Inf handling are exactly those of bfloat16_mult / bfloat16_adder. This block adds no conversion.
- Packet length is unbounded. The accumulator never wraps; it saturates only as the adder cell does (Inf).

Optional Feature:
- Macro: BF16_DOTPROD_NAN_FLAG_EN.
- Defined:
  - Adds output out_nan (1 bit), valid with out_data.
  - Set if any product, tree sum or accumulator value of the packet had exponent 0xFF with nonzero mantissa.
  - Sticky per packet, cleared with the accumulator. Reset value 0. Held during stall.
- Undefined: port and logic absent. Behaviour is otherwise identical.

Test Plan:
- VEC_LEN=8, one beat: all horz=0x3F80, vert=0x4000, in_last=1 → out_valid exactly 6 cycles after acceptance, out_data=0x4180 (16.0).
- 3-beat packet: all lanes 0x3F80×0x3F80, in_last on beat 3 only → single result 0x41C0 (24.0), no output after beats 1–2.
- Backpressure: hold out_ready=0 with a result pending and in_valid=1 → in_ready=0, out_data and pipeline frozen. Release → result consumed, the next packet result (lane0 0x4040×0x4000, others 0) = 0x40C0 appears in order with no loss or duplication.
- Back-to-back single-beat packets every cycle, out_ready=1: lane0 = 1.0×k for k=1..4, others 0 → outputs 0x3F80, 0x4000, 0x4040, 0x4080 on consecutive cycles.
- Assert rst_n=0 mid-packet after 2 non-last beats → out_valid=0 at once. The next single-beat packet (8×0x3F80·0x3F00) yields 0x4080 (4.0), with no residue from the aborted packet.
- With BF16_DOTPROD_NAN_FLAG_EN: lane0 horz=0x7FC0, in_last=1 → out_nan=1. The following clean packet → out_nan=0.
